test_pattern_xmit: RTL

Transmit-side traffic generator for the MAC link test. It emits a programmable number of Ethernet frames, each with a fixed-length payload. Every payload carries the packet index, a 16-bit timestamp and a deterministic byte pattern. Frames are separated by a programmable idle gap. Output is a header/payload stream toward the Ethernet frame transmitter; the far-end pattern receiver checks the data and computes latency from the embedded timestamp.

---
 rtl/test_pattern_pkg.sv | 33 +++
 rtl/test_pattern_xmit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_pkg.sv
// -----------------------------------------------------------------------------
// test_pattern_pkg
// Shared definitions for the link-test pattern generator and its far-end
// checker. Both ends import this package so that they agree on the payload
// layout: packet index (LSB first), 16-bit timestamp (LSB first), and then a
// deterministic byte ramp seeded by the low byte of the packet index.
// -----------------------------------------------------------------------------
package test_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_GAP,
    ST_DONE
  } state_t;

  // Byte offsets inside the payload.
  localparam logic [15:0] OFS_INDEX0 = 16'd0;
  localparam logic [15:0] OFS_INDEX1 = 16'd1;
  localparam logic [15:0] OFS_TS0    = 16'd2;
  localparam logic [15:0] OFS_TS1    = 16'd3;
  localparam logic [15:0] OFS_DATA   = 16'd4;

  localparam logic [15:0] DEFAULT_ETH_TYPE = 16'h88B5;

  // Ramp byte for offsets at or beyond OFS_DATA; the sum wraps modulo 256.
  function automatic logic [7:0] pattern_byte(input logic [7:0] index,
                                              input logic [7:0] offset);
    return index + offset;
  endfunction

endpackage

// File: rtl/test_pattern_xmit.sv
// -----------------------------------------------------------------------------
// test_pattern_xmit
// Transmit-side traffic generator for the MAC link test. Emits a run of
// frame_count frames (0 = run until enable drops), each a header handshake
// followed by DATA_LENGTH payload beats, with gap_cycles idle cycles between
// a frame's last beat and the next header. A frame, once its header is
// pending, always completes; dropping enable stops the run at the next frame
// boundary.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                level; high starts and sustains a run
//   frame_count           frames per run (0 = continuous), latched at start
//   gap_cycles            idle cycles between frames, latched at start
//   src_mac, dst_mac      copied into every header
//   timestamp             free-running time base, captured at header handshake
//   busy / done           status: running / finished a counted run
//   packet_index          index of the current/next frame (runs across runs)
//   sent_count            frames completed in the current run
//   m_eth_hdr_*           header channel toward the frame transmitter
//   m_eth_payload_axis_*  8-bit payload stream toward the frame transmitter
// -----------------------------------------------------------------------------
module test_pattern_xmit
  import test_pattern_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = 64,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic [15:0] ETH_TYPE    = DEFAULT_ETH_TYPE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [15:0]           frame_count,
  input  logic [15:0]           gap_cycles,
  input  logic [47:0]           src_mac,
  input  logic [47:0]           dst_mac,
  input  logic [15:0]           timestamp,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           packet_index,
  output logic [15:0]           sent_count,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser
);

  localparam logic [15:0] LAST_BEAT = 16'(DATA_LENGTH - 1);

  state_t      state_q, state_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] ts_q, ts_d;
  logic [15:0] index_d;
  logic [15:0] sent_d;
  logic        hdr_fire;
  logic        beat_fire;

  assign m_eth_payload_axis_tuser = 1'b0;

  assign hdr_fire  = m_eth_hdr_valid && m_eth_hdr_ready;
  assign beat_fire = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready;

  // Payload byte at beat b of the frame carrying index idx and timestamp ts.
  function automatic logic [7:0] payload_byte(input logic [15:0] b,
                                              input logic [15:0] idx,
                                              input logic [15:0] ts);
    case (b)
      OFS_INDEX0: return idx[7:0];
      OFS_INDEX1: return idx[15:8];
      OFS_TS0:    return ts[7:0];
      OFS_TS1:    return ts[15:8];
      default:    return pattern_byte(idx[7:0], b[7:0]);
    endcase
  endfunction

  // NOTE: every variable written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    gap_cnt_d     = gap_cnt_q;
    frame_count_d = frame_count_q;
    gap_d         = gap_q;
    ts_d          = ts_q;
    index_d       = packet_index;
    sent_d        = sent_count;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d       = ST_HDR;
          frame_count_d = frame_count;
          gap_d         = gap_cycles;
          sent_d        = 16'd0;
        end
      end

      ST_HDR: begin
        if (hdr_fire) begin
          state_d = ST_PAYLOAD;
          ts_d    = timestamp;
          beat_d  = 16'd0;
        end
      end

      ST_PAYLOAD: begin
        if (beat_fire) begin
          if (m_eth_payload_axis_tlast) begin
            index_d = packet_index + 16'd1;
            sent_d  = sent_count + 16'd1;
            if (frame_count_q != 16'd0 && sent_d == frame_count_q) begin
              state_d = ST_DONE;
            end else if (!enable) begin
              state_d = ST_IDLE;
            end else if (gap_q == 16'd0) begin
              state_d = ST_HDR;
            end else begin
              state_d   = ST_GAP;
              // The first GAP cycle is already one of the gap_q cycles.
              gap_cnt_d = gap_q - 16'd1;
            end
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end

      ST_GAP: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q == 16'd0) begin
          state_d = ST_HDR;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end

      ST_DONE: begin
        if (!enable) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Every output is registered from the next-state values, so each one moves
  // in the same cycle as the state it reflects.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                   <= ST_IDLE;
      beat_q                    <= '0;
      gap_cnt_q                 <= '0;
      frame_count_q             <= '0;
      gap_q                     <= '0;
      ts_q                      <= '0;
      packet_index              <= '0;
      sent_count                <= '0;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      m_eth_hdr_valid           <= 1'b0;
      m_eth_dest_mac            <= '0;
      m_eth_src_mac             <= '0;
      m_eth_type                <= '0;
      m_eth_payload_axis_tdata  <= '0;
      m_eth_payload_axis_tvalid <= 1'b0;
      m_eth_payload_axis_tlast  <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_count_q <= frame_count_d;
      gap_q         <= gap_d;
      ts_q          <= ts_d;
      packet_index  <= index_d;
      sent_count    <= sent_d;

      busy            <= state_d inside {ST_HDR, ST_PAYLOAD, ST_GAP};
      done            <= (state_d == ST_DONE);
      m_eth_hdr_valid <= (state_d == ST_HDR);

      // Header fields are captured on entry so they hold through a stall.
      if (state_d == ST_HDR && state_q != ST_HDR) begin
        m_eth_dest_mac <= dst_mac;
        m_eth_src_mac  <= src_mac;
        m_eth_type     <= ETH_TYPE;
      end

      m_eth_payload_axis_tvalid <= (state_d == ST_PAYLOAD);
      m_eth_payload_axis_tlast  <= (state_d == ST_PAYLOAD) && (beat_d == LAST_BEAT);
      // beat_d only advances on a beat handshake, so tdata holds while stalled.
      if (state_d == ST_PAYLOAD) begin
        m_eth_payload_axis_tdata <= payload_byte(beat_d, index_d, ts_d);
      end
    end
  end

endmodule
